// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays fixed note sequences (EAT, GAMEOVER) from an internal
// ROM into the synthesizer tone generator. Each note holds a frequency for a
// number of prescaled ticks while `signal` is high.
// Optional feature: define SFX_GAP_EN to insert GAP_TICKS silent ticks
// between consecutive notes of a sequence (none after the last note).
module sfx_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eat,
  input  logic        game_over,
  output logic [11:0] in_freq,
  output logic        signal,
  output logic        busy,
  output logic        done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  // Duration field is 9 bits wide so the 400-tick closing note fits.
  localparam int DW  = 9;

  localparam logic [2:0] EAT_ADDR = 3'd0;
  localparam logic [2:0] GO_ADDR  = 3'd3;

  typedef struct packed {
    logic [11:0]   freq;
    logic [DW-1:0] dur;
  } rom_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
`ifdef SFX_GAP_EN
    GAP,
`endif
    FINISH
  } state_t;

  // Constant note table; dur == 0 marks the end of a sequence.
  function automatic rom_entry_t rom_lookup(input logic [2:0] a);
    rom_entry_t e;
    e = '{freq: 12'd0, dur: '0};
    case (a)
      3'd0:    e = '{freq: 12'd880,  dur: 9'd40};
      3'd1:    e = '{freq: 12'd1320, dur: 9'd60};
      3'd3:    e = '{freq: 12'd440,  dur: 9'd200};
      3'd4:    e = '{freq: 12'd330,  dur: 9'd200};
      3'd5:    e = '{freq: 12'd220,  dur: 9'd400};
      default: e = '{freq: 12'd0,    dur: '0};
    endcase
    return e;
  endfunction

  state_t        state, state_next;
  logic [2:0]    addr, addr_next;
  logic          go_seq, go_seq_next;   // active sequence is GAMEOVER
  logic [11:0]   freq_q;
  logic [DW-1:0] dur_q;
  logic [PW-1:0] presc;
  logic [DW-1:0] tick_cnt;
  logic          tick;
  logic          timed;
  logic          cnt_clr;
  rom_entry_t    rom_q;
`ifdef SFX_GAP_EN
  rom_entry_t    rom_nx;
`endif

  assign tick = (presc == PW'(DIV - 1));

  // ROM reads for the current entry (and the next one, to skip a trailing gap).
  always_comb begin
    rom_q = rom_lookup(addr);
`ifdef SFX_GAP_EN
    rom_nx = rom_lookup(addr + 3'd1);
`endif
  end

  // Next-state logic: sequence progress first, then triggers override it.
  always_comb begin
    // NOTE: every variable gets a default here so no latch is inferred.
    state_next  = state;
    addr_next   = addr;
    go_seq_next = go_seq;
    timed       = 1'b0;

    case (state)
      IDLE: ;
      LOAD: state_next = (rom_q.dur == '0) ? FINISH : PLAY;
      PLAY: begin
        timed = 1'b1;
        if (tick && (tick_cnt + 9'd1 == dur_q)) begin
          addr_next = addr + 3'd1;
`ifdef SFX_GAP_EN
          state_next = (rom_nx.dur == '0) ? LOAD : GAP;
`else
          state_next = LOAD;
`endif
        end
      end
`ifdef SFX_GAP_EN
      GAP: begin
        timed = 1'b1;
        if (tick && (tick_cnt + 9'd1 == DW'(GAP_TICKS)))
          state_next = LOAD;
      end
`endif
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // GAMEOVER preempts anything; EAT restarts EAT but never interrupts GAMEOVER.
    if (game_over) begin
      state_next  = LOAD;
      addr_next   = GO_ADDR;
      go_seq_next = 1'b1;
    end else if (eat && !(go_seq && state != IDLE && state != FINISH)) begin
      state_next  = LOAD;
      addr_next   = EAT_ADDR;
      go_seq_next = 1'b0;
    end

    // Prescaler and tick counter restart at every note or gap start.
    cnt_clr = !timed || (state_next != state);
  end

  // State register and sequence position.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      go_seq <= 1'b0;
    end else begin
      state  <= state_next;
      addr   <= addr_next;
      go_seq <= go_seq_next;
    end
  end

  // Latch the note on LOAD -> PLAY and run the tick prescaler/counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q   <= '0;
      dur_q    <= '0;
      presc    <= '0;
      tick_cnt <= '0;
    end else begin
      if (state == LOAD && state_next == PLAY) begin
        freq_q <= rom_q.freq;
        dur_q  <= rom_q.dur;
      end
      if (cnt_clr) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + 9'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Registered outputs derived from the current state; LOAD holds the tone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_freq <= '0;
      signal  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state != IDLE) && (state != FINISH);
      done <= (state == FINISH);
      case (state)
        PLAY: begin
          signal  <= 1'b1;
          in_freq <= freq_q;
        end
        LOAD: ;
`ifdef SFX_GAP_EN
        GAP: signal <= 1'b0;
`endif
        default: begin
          signal  <= 1'b0;
          in_freq <= '0;
        end
      endcase
    end
  end

  // The ROM is a constant table, so it has no reset and no storage.

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed bench for sfx_sequencer at 10 cycles per tick.
// Expected cycle counts are hand-derived relative to the trigger edge N:
// LOAD at N, first note sampled from N+2, one LOAD cycle per note boundary.
module tb_sfx_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;

`ifdef SFX_GAP_EN
  localparam int EAT_DONE   = 1104;
  localparam int EAT_880    = 400;
  localparam int EAT_SIG    = 1001;
  localparam int RST_DONE   = 1405;
  localparam int RST_880    = 701;
  localparam int GO_DONE    = 8205;
  localparam int GO_440     = 2000;
  localparam int GO_330     = 2000;
  localparam int GO_SIG     = 8001;
`else
  localparam int EAT_DONE   = 1004;
  localparam int EAT_880    = 401;
  localparam int EAT_SIG    = 1002;
  localparam int RST_DONE   = 1305;
  localparam int RST_880    = 702;
  localparam int GO_DONE    = 8005;
  localparam int GO_440     = 2001;
  localparam int GO_330     = 2001;
  localparam int GO_SIG     = 8003;
`endif
  localparam int GO_220   = 4001;
  localparam int EAT_1320 = 601;

  logic        clk = 1'b0;
  logic        rst;
  logic        eat;
  logic        game_over;
  logic [11:0] in_freq;
  logic        signal;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by watch().
  int busy_cnt, sig_cnt, done_cnt, done_at, first440;
  int c880, c1320, c440, c330, c220;

  sfx_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .GAP_TICKS(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .eat      (eat),
    .game_over(game_over),
    .in_freq  (in_freq),
    .signal   (signal),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle trigger pulse; the sampling edge N lies between the two negedges.
  task automatic pulse(input logic e, input logic g);
    @(negedge clk);
    eat       = e;
    game_over = g;
    @(negedge clk);
    eat       = 1'b0;
    game_over = 1'b0;
  endtask

  // Sample outputs after edges N+1..N+nk; optionally inject a trigger at step inj_at.
  task automatic watch(input int nk, input int inj_at, input logic inj_eat, input logic inj_go);
    busy_cnt = 0; sig_cnt = 0; done_cnt = 0; done_at = -1; first440 = -1;
    c880 = 0; c1320 = 0; c440 = 0; c330 = 0; c220 = 0;
    for (int k = 1; k <= nk; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (signal) begin
        sig_cnt++;
        case (in_freq)
          12'd880:  c880++;
          12'd1320: c1320++;
          12'd440:  c440++;
          12'd330:  c330++;
          12'd220:  c220++;
          default: ;
        endcase
        if (in_freq == 12'd440 && first440 < 0) first440 = k;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      eat       = (k == inj_at) && inj_eat;
      game_over = (k == inj_at) && inj_go;
    end
    eat       = 1'b0;
    game_over = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    eat       = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_freq", in_freq, 0);
    check("rst_signal", signal, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Idle with no triggers.
    watch(100, 0, 1'b0, 1'b0);
    check("idle_busy", busy_cnt, 0);
    check("idle_signal", sig_cnt, 0);
    check("idle_done", done_cnt, 0);

    // Asynchronous reset in the middle of a note.
    pulse(1'b1, 1'b0);
    watch(200, 0, 1'b0, 1'b0);
    check("mid_880", c880, 199);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_in_freq", in_freq, 0);
    check("async_signal", signal, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain EAT sequence.
    pulse(1'b1, 1'b0);
    watch(1200, 0, 1'b0, 1'b0);
    check("eat_880", c880, EAT_880);
    check("eat_1320", c1320, EAT_1320);
    check("eat_signal", sig_cnt, EAT_SIG);
    check("eat_done_at", done_at, EAT_DONE);
    check("eat_done_cnt", done_cnt, 1);
    check("eat_busy", busy_cnt, EAT_DONE - 1);
    check("eat_end_freq", in_freq, 0);
    check("eat_end_signal", signal, 0);

    // Plain GAMEOVER sequence.
    pulse(1'b0, 1'b1);
    watch(8400, 0, 1'b0, 1'b0);
    check("go_first440", first440, 2);
    check("go_440", c440, GO_440);
    check("go_330", c330, GO_330);
    check("go_220", c220, GO_220);
    check("go_signal", sig_cnt, GO_SIG);
    check("go_done_at", done_at, GO_DONE);
    check("go_done_cnt", done_cnt, 1);
    check("go_busy", busy_cnt, GO_DONE - 1);

    // Simultaneous triggers: GAMEOVER wins.
    pulse(1'b1, 1'b1);
    watch(8400, 0, 1'b0, 1'b0);
    check("both_first440", first440, 2);
    check("both_880", c880, 0);
    check("both_done_at", done_at, GO_DONE);

    // GAMEOVER preempts EAT 150 cycles in; only one done, at the GAMEOVER end.
    pulse(1'b1, 1'b0);
    watch(8400, 150, 1'b0, 1'b1);
    check("pre_880", c880, 151);
    check("pre_first440", first440, 153);
    check("pre_done_cnt", done_cnt, 1);
    check("pre_done_at", done_at, 151 + GO_DONE);

    // EAT during GAMEOVER is ignored.
    pulse(1'b0, 1'b1);
    watch(8400, 500, 1'b1, 1'b0);
    check("ign_880", c880, 0);
    check("ign_440", c440, GO_440);
    check("ign_330", c330, GO_330);
    check("ign_220", c220, GO_220);
    check("ign_done_at", done_at, GO_DONE);

    // EAT re-pulsed 300 cycles in restarts the 880 Hz note.
    pulse(1'b1, 1'b0);
    watch(1500, 300, 1'b1, 1'b0);
    check("re_880", c880, RST_880);
    check("re_1320", c1320, EAT_1320);
    check("re_done_at", done_at, RST_DONE);
    check("re_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
